// File: rtl/rv_dmem_ctrl.sv
// Data-memory controller: a 32-bit RAM with a synchronous read port and a
// memory-mapped output register. Byte/half/word loads and stores, with
// alignment and decode faults reported on the completion pulse.
module rv_dmem_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] GPIO_ADDR   = 32'h8000_0000,
  parameter int unsigned GPIO_W      = 8,
  parameter logic [31:0] GPIO_RST    = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              ack_o,
  output logic              err_o,
  output logic              busy_o,
  output logic [GPIO_W-1:0] gpio_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {IDLE, RD, ACK} state_t;

  state_t            state, state_nxt;
  logic [31:0]       mem [DEPTH_WORDS];
  logic [31:0]       rd_word;
  logic [31:0]       off;
  logic [AW-1:0]     idx;
  logic              ram_sel, gpio_sel, misalign, fault, accept;
  logic              ram_we, gpio_we;
  logic [3:0]        be;
  logic [31:0]       wword;
  logic              err_q, uns_q, gpio_rd_q;
  logic [1:0]        addr_q, size_q;
  logic [31:0]       rdata_q, fmt, gpio_ext;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [GPIO_W-1:0] gpio_q;

  // Address decode, fault detection and store lane generation
  always_comb begin
    off      = addr_i - BASE_ADDR;
    idx      = off[AW+1:2];
    ram_sel  = off < RAM_BYTES;
    gpio_sel = (addr_i == GPIO_ADDR) && !ram_sel;
    misalign = (size_i == 2'b01 && addr_i[0]) ||
               (size_i == 2'b10 && addr_i[1:0] != 2'b00);
    fault    = (!ram_sel && !gpio_sel) || (size_i == 2'b11) || misalign ||
               (gpio_sel && size_i != 2'b10);
    accept   = (state == IDLE) && req_i && !rst_i;
    ram_we   = accept && we_i && !fault && ram_sel;
    gpio_we  = accept && we_i && !fault && gpio_sel;
    case (size_i)
      2'b00:   begin be = 4'b0001 << addr_i[1:0];              wword = {4{wdata_i[7:0]}};  end
      2'b01:   begin be = addr_i[1] ? 4'b1100 : 4'b0011;       wword = {2{wdata_i[15:0]}}; end
      default: begin be = 4'b1111;                             wword = wdata_i;            end
    endcase
  end

  // RAM array: byte-enabled write and registered read on the accept edge; no reset
  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wword[i*8 +: 8];
      end
    end
    if (accept) rd_word <= mem[idx];
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: faults and stores complete directly, loads pass through RD
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_i) state_nxt = (fault || we_i) ? ACK : RD;
      RD:      state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Load lane extraction and sign/zero extension
  always_comb begin
    byte_sel = rd_word[addr_q*8 +: 8];
    half_sel = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (size_q)
      2'b00:   fmt = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   fmt = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: fmt = rd_word;
    endcase
    gpio_ext = '0;
    gpio_ext[GPIO_W-1:0] = gpio_q;
  end

  // Access attributes, result register and output register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q   <= 1'b0;
      rdata_q <= '0;
      gpio_q  <= GPIO_RST[GPIO_W-1:0];
    end else if (accept) begin
      err_q     <= fault;
      rdata_q   <= '0;
      addr_q    <= addr_i[1:0];
      size_q    <= size_i;
      uns_q     <= unsigned_i;
      gpio_rd_q <= gpio_sel;
      if (gpio_we) gpio_q <= wdata_i[GPIO_W-1:0];
    end else if (state == RD) begin
      rdata_q <= gpio_rd_q ? gpio_ext : fmt;
    end
  end

  assign ack_o   = (state == ACK);
  assign err_o   = ack_o & err_q;
  assign rdata_o = ack_o ? rdata_q : '0;
  assign busy_o  = (state != IDLE);
  assign gpio_o  = gpio_q;

endmodule

// File: tb/tb_rv_dmem_ctrl.sv
// Directed bench for rv_dmem_ctrl: a table of single accesses with hand
// computed results, then reset-abort, reset-priority and back-to-back sequences.
module tb_rv_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst, req, we, uns;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic [31:0] rdata;
  logic        ack, err, busy;
  logic [7:0]  gpio;

  int n_chk  = 0;
  int n_fail = 0;

  rv_dmem_ctrl #(
    .BASE_ADDR  (32'h0000_1000),
    .DEPTH_WORDS(256),
    .GPIO_ADDR  (32'h8000_0000),
    .GPIO_W     (8),
    .GPIO_RST   (32'h0)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .size_i(size), .unsigned_i(uns), .wdata_i(wdata), .rdata_o(rdata),
    .ack_o(ack), .err_o(err), .busy_o(busy), .gpio_o(gpio)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    logic [7:0]  gpio;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic w, logic [31:0] a, logic [1:0] s, logic u,
                              logic [31:0] d, int l, logic e, logic [31:0] r,
                              logic [7:0] g);
    vec_t v;
    v.we = w; v.addr = a; v.size = s; v.uns = u; v.wdata = d;
    v.lat = l; v.err = e; v.rdata = r; v.gpio = g;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One access from IDLE; returns cycles from accept edge to ack (99 = timeout)
  task automatic do_access(input logic w, input logic [31:0] a, input logic [1:0] s,
                           input logic u, input logic [31:0] d,
                           output int lat, output logic e, output logic [31:0] r);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; size = s; uns = u; wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 99; e = 1'bx; r = 'x;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (ack) begin
        lat = i; e = err; r = rdata;
        break;
      end
    end
  endtask

  int          lat;
  logic        e;
  logic [31:0] r;
  logic        seq_we   [10];
  logic [31:0] seq_wd   [10];
  logic        seq_ack  [10];
  logic        seq_busy [10];
  logic [31:0] seq_rd   [10];

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; uns = 1'b0;
    addr = '0; wdata = '0; size = 2'b10;

    //            we  addr           sz    u  wdata          lat err rdata          gpio
    vecs.push_back(mk(1, 32'h0000_1004, 2'b10, 0, 32'hDEAD_BEEF, 1, 0, 32'h0,         8'h00));
    vecs.push_back(mk(0, 32'h0000_1004, 2'b10, 0, 32'h0,         2, 0, 32'hDEAD_BEEF, 8'h00));
    vecs.push_back(mk(0, 32'h0000_1005, 2'b00, 1, 32'h0,         2, 0, 32'h0000_00BE, 8'h00));
    vecs.push_back(mk(1, 32'h0000_1000, 2'b10, 0, 32'h1122_3344, 1, 0, 32'h0,         8'h00));
    vecs.push_back(mk(1, 32'h0000_1002, 2'b01, 0, 32'h0000_8001, 1, 0, 32'h0,         8'h00));
    vecs.push_back(mk(0, 32'h0000_1000, 2'b10, 0, 32'h0,         2, 0, 32'h8001_3344, 8'h00));
    vecs.push_back(mk(0, 32'h0000_1002, 2'b01, 0, 32'h0,         2, 0, 32'hFFFF_8001, 8'h00));
    vecs.push_back(mk(0, 32'h0000_1002, 2'b01, 1, 32'h0,         2, 0, 32'h0000_8001, 8'h00));
    vecs.push_back(mk(0, 32'h0000_1003, 2'b00, 0, 32'h0,         2, 0, 32'hFFFF_FF80, 8'h00));
    vecs.push_back(mk(0, 32'h0000_1000, 2'b00, 0, 32'h0,         2, 0, 32'h0000_0044, 8'h00));
    vecs.push_back(mk(0, 32'h0000_1002, 2'b10, 0, 32'h0,         1, 1, 32'h0,         8'h00));
    vecs.push_back(mk(1, 32'h0000_1400, 2'b10, 0, 32'hFFFF_FFFF, 1, 1, 32'h0,         8'h00));
    vecs.push_back(mk(0, 32'h0000_0FFC, 2'b10, 0, 32'h0,         1, 1, 32'h0,         8'h00));
    vecs.push_back(mk(1, 32'h0000_1001, 2'b01, 0, 32'h0000_FFFF, 1, 1, 32'h0,         8'h00));
    vecs.push_back(mk(0, 32'h0000_1000, 2'b11, 0, 32'h0,         1, 1, 32'h0,         8'h00));
    vecs.push_back(mk(0, 32'h0000_1000, 2'b10, 0, 32'h0,         2, 0, 32'h8001_3344, 8'h00));
    vecs.push_back(mk(1, 32'h0000_1006, 2'b00, 0, 32'h1234_565A, 1, 0, 32'h0,         8'h00));
    vecs.push_back(mk(0, 32'h0000_1004, 2'b10, 0, 32'h0,         2, 0, 32'hDE5A_BEEF, 8'h00));
    vecs.push_back(mk(0, 32'h0000_1006, 2'b01, 1, 32'h0,         2, 0, 32'h0000_DE5A, 8'h00));
    vecs.push_back(mk(1, 32'h0000_13FC, 2'b10, 0, 32'h0000_0000, 1, 0, 32'h0,         8'h00));
    vecs.push_back(mk(1, 32'h0000_13FF, 2'b00, 0, 32'h0000_007F, 1, 0, 32'h0,         8'h00));
    vecs.push_back(mk(0, 32'h0000_13FC, 2'b10, 0, 32'h0,         2, 0, 32'h7F00_0000, 8'h00));
    vecs.push_back(mk(0, 32'h0000_13FF, 2'b00, 0, 32'h0,         2, 0, 32'h0000_007F, 8'h00));
    vecs.push_back(mk(1, 32'h8000_0000, 2'b10, 0, 32'h0000_00A5, 1, 0, 32'h0,         8'hA5));
    vecs.push_back(mk(0, 32'h8000_0000, 2'b10, 0, 32'h0,         2, 0, 32'h0000_00A5, 8'hA5));
    vecs.push_back(mk(1, 32'h8000_0000, 2'b00, 0, 32'h0000_00FF, 1, 1, 32'h0,         8'hA5));
    vecs.push_back(mk(0, 32'h8000_0000, 2'b00, 0, 32'h0,         1, 1, 32'h0,         8'hA5));
    vecs.push_back(mk(1, 32'h8000_0004, 2'b10, 0, 32'h0000_0011, 1, 1, 32'h0,         8'hA5));

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack",   32'(ack),   32'h0);
    chk("rst_err",   32'(err),   32'h0);
    chk("rst_rdata", rdata,      32'h0);
    chk("rst_busy",  32'(busy),  32'h0);
    chk("rst_gpio",  32'(gpio),  32'h0);
    rst = 1'b0;

    // Table of single accesses
    foreach (vecs[i]) begin
      do_access(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata, lat, e, r);
      chk($sformatf("v%0d_lat", i),   32'(lat),  32'(vecs[i].lat));
      chk($sformatf("v%0d_err", i),   32'(e),    32'(vecs[i].err));
      chk($sformatf("v%0d_rdata", i), r,         vecs[i].rdata);
      chk($sformatf("v%0d_gpio", i),  32'(gpio), 32'(vecs[i].gpio));
    end

    // Reset while a load sits in RD: dropped, output register restored
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h0000_1000; size = 2'b10; uns = 1'b0;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    chk("rd_busy", 32'(busy), 32'h1);
    chk("rd_ack",  32'(ack),  32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_gpio", 32'(gpio), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("abort_noack%0d", i), 32'(ack), 32'h0);
    end
    do_access(1'b0, 32'h0000_1000, 2'b10, 1'b0, 32'h0, lat, e, r);
    chk("post_rst_lat",   32'(lat), 32'h2);
    chk("post_rst_rdata", r,        32'h8001_3344);

    // Reset wins over a simultaneous output-register store
    @(negedge clk);
    rst = 1'b1; req = 1'b1; we = 1'b1; addr = 32'h8000_0000; size = 2'b10; wdata = 32'h0000_00A5;
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    chk("prio_gpio", 32'(gpio), 32'h0);
    chk("prio_busy", 32'(busy), 32'h0);
    @(negedge clk);
    chk("prio_noack", 32'(ack), 32'h0);

    // Continuous request, store/load alternating; accepts at edges 0,2,5,7
    for (int k = 0; k < 10; k++) begin
      seq_we[k] = 1'b1; seq_wd[k] = 32'hFFFF_FFFF;
      seq_ack[k] = 1'b0; seq_busy[k] = 1'b0; seq_rd[k] = 32'h0;
    end
    seq_wd[0] = 32'h1234_5678;
    seq_we[2] = 1'b0;
    seq_wd[5] = 32'hCAFE_F00D;
    seq_we[7] = 1'b0;
    seq_ack[0] = 1'b1; seq_ack[3] = 1'b1; seq_ack[5] = 1'b1; seq_ack[8] = 1'b1;
    seq_busy[0] = 1'b1; seq_busy[2] = 1'b1; seq_busy[3] = 1'b1;
    seq_busy[5] = 1'b1; seq_busy[7] = 1'b1; seq_busy[8] = 1'b1;
    seq_rd[3] = 32'h1234_5678;
    seq_rd[8] = 32'hCAFE_F00D;
    addr = 32'h0000_1010; size = 2'b10; uns = 1'b0;
    for (int k = 0; k < 10; k++) begin
      req = 1'b1; we = seq_we[k]; wdata = seq_wd[k];
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("b2b%0d_ack", k),   32'(ack),  32'(seq_ack[k]));
      chk($sformatf("b2b%0d_busy", k),  32'(busy), 32'(seq_busy[k]));
      chk($sformatf("b2b%0d_rdata", k), rdata,     seq_rd[k]);
    end
    req = 1'b0;
    do_access(1'b0, 32'h0000_1010, 2'b10, 1'b0, 32'h0, lat, e, r);
    chk("b2b_final", r, 32'hCAFE_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
